// File: rtl/alarm_clock_core.sv
// rtl/alarm_clock_core.sv - 24-hour timekeeping core with multi-slot alarms, snooze and ring timeout
module alarm_clock_core #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_MIN   = 10,
  localparam int SEL_W     = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [1:0]            mode,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic                  hour_up,
  input  logic                  min_up,
  input  logic                  snooze,
  input  logic                  alarm_off,
  output logic [4:0]            hours,
  output logic [5:0]            minutes,
  output logic [5:0]            seconds,
  output logic                  alarm,
  output logic [2:0]            alarm_id,
  output logic [NUM_ALARMS-1:0] alarm_en,
  output logic                  sec_pulse
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [1:0] M_SET_TIME  = 2'd1;
  localparam logic [1:0] M_SET_ALARM = 2'd2;
  localparam logic [1:0] M_ALARM_EN  = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RING, S_SNOOZE} state_t;

  state_t         state, state_nx;
  logic [2:0]     id_nx;
  logic [5:0]     ring_cnt, cnt_nx;
  logic [TW-1:0]  tick_cnt;
  logic           prev_h, prev_m, prev_s, prev_o;
  logic           ev_h, ev_m, ev_s, ev_o;
  logic           set_time_m, min_roll, zero_flag, sel_ok;
  logic           match;
  logic [2:0]     match_id;
  logic [4:0]     alarm_hr [NUM_ALARMS];
  logic [5:0]     alarm_mn [NUM_ALARMS];

  function automatic logic [5:0] inc_min(input logic [5:0] m);
    return (m == 6'd59) ? 6'd0 : m + 6'd1;
  endfunction

  function automatic logic [4:0] inc_hr(input logic [4:0] h);
    return (h == 5'd23) ? 5'd0 : h + 5'd1;
  endfunction

  assign ev_h       = hour_up & ~prev_h;
  assign ev_m       = min_up & ~prev_m;
  assign ev_s       = snooze & ~prev_s;
  assign ev_o       = alarm_off & ~prev_o;
  assign set_time_m = (mode == M_SET_TIME);
  assign sec_pulse  = !set_time_m && (tick_cnt == TW'(TICK_DIV - 1));
  assign min_roll   = sec_pulse && (seconds == 6'd59);
  assign sel_ok     = {1'b0, alarm_sel} < (SEL_W + 1)'(NUM_ALARMS);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tick_cnt  <= '0;
      hours     <= '0;
      minutes   <= '0;
      seconds   <= '0;
      zero_flag <= 1'b0;
      prev_h    <= 1'b0;
      prev_m    <= 1'b0;
      prev_s    <= 1'b0;
      prev_o    <= 1'b0;
    end else begin
      prev_h    <= hour_up;
      prev_m    <= min_up;
      prev_s    <= snooze;
      prev_o    <= alarm_off;
      // zero_flag marks "seconds just reached 0 by a real tick"; hand-set times never qualify
      zero_flag <= min_roll;
      if (set_time_m) begin
        tick_cnt <= '0;
        seconds  <= '0;
        if (ev_m) minutes <= inc_min(minutes);
        if (ev_h) hours   <= inc_hr(hours);
      end else begin
        tick_cnt <= sec_pulse ? '0 : tick_cnt + TW'(1);
        if (sec_pulse) begin
          if (seconds == 6'd59) begin
            seconds <= '0;
            if (minutes == 6'd59) begin
              minutes <= '0;
              hours   <= inc_hr(hours);
            end else begin
              minutes <= minutes + 6'd1;
            end
          end else begin
            seconds <= seconds + 6'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      alarm_en <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        alarm_hr[i] <= '0;
        alarm_mn[i] <= '0;
      end
    end else if (sel_ok) begin
      if (mode == M_SET_ALARM) begin
        if (ev_m) alarm_mn[alarm_sel] <= inc_min(alarm_mn[alarm_sel]);
        if (ev_h) alarm_hr[alarm_sel] <= inc_hr(alarm_hr[alarm_sel]);
      end else if (mode == M_ALARM_EN && ev_m) begin
        alarm_en[alarm_sel] <= ~alarm_en[alarm_sel];
      end
    end
  end

  // Descending scan so the lowest matching slot is the one left standing
  always_comb begin
    match    = 1'b0;
    match_id = 3'd0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (zero_flag && alarm_en[i] && alarm_hr[i] == hours && alarm_mn[i] == minutes) begin
        match    = 1'b1;
        match_id = 3'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= S_IDLE;
      alarm_id <= '0;
      ring_cnt <= '0;
    end else begin
      state    <= state_nx;
      alarm_id <= id_nx;
      ring_cnt <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    id_nx    = alarm_id;
    cnt_nx   = ring_cnt;
    if (set_time_m) begin
      state_nx = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (match) begin
          state_nx = S_RING;
          id_nx    = match_id;
          cnt_nx   = '0;
        end
        S_RING: begin
          if (ev_o) begin
            state_nx = S_IDLE;
          end else if (ev_s) begin
            state_nx = S_SNOOZE;
            cnt_nx   = '0;
          end else if (min_roll) begin
            cnt_nx = ring_cnt + 6'd1;
            if (cnt_nx == 6'(RING_MIN)) state_nx = S_IDLE;
          end
        end
        S_SNOOZE: begin
          if (ev_o) begin
            state_nx = S_IDLE;
          end else if (match) begin
            state_nx = S_RING;
            id_nx    = match_id;
            cnt_nx   = '0;
          end else if (min_roll) begin
            cnt_nx = ring_cnt + 6'd1;
            if (cnt_nx == 6'(SNOOZE_MIN)) begin
              state_nx = S_RING;
              cnt_nx   = '0;
            end
          end
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_comb begin
    alarm = (state == S_RING);
  end

endmodule

// File: tb/tb_alarm_clock_core.sv
// tb/tb_alarm_clock_core.sv - directed and random checks of alarm_clock_core against a seconds-of-day model
module tb_alarm_clock_core;
  localparam int TD = 4, NA = 4, SNZ = 5, RNG = 10;

  logic       clk = 1'b0;
  logic       clr;
  logic [1:0] mode, alarm_sel;
  logic       hour_up, min_up, snooze, alarm_off;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic       alarm;
  logic [2:0] alarm_id;
  logic [3:0] alarm_en;
  logic       sec_pulse;

  alarm_clock_core #(.TICK_DIV(TD), .NUM_ALARMS(NA), .SNOOZE_MIN(SNZ), .RING_MIN(RNG)) dut (
    .clk(clk), .clr(clr), .mode(mode), .alarm_sel(alarm_sel), .hour_up(hour_up),
    .min_up(min_up), .snooze(snooze), .alarm_off(alarm_off), .hours(hours),
    .minutes(minutes), .seconds(seconds), .alarm(alarm), .alarm_id(alarm_id),
    .alarm_en(alarm_en), .sec_pulse(sec_pulse)
  );

  always #5 clk = ~clk;

  int n_asrt = 0, n_fail = 0;

  // Model: time as seconds of day, alarms as minute of day, FSM as 0 idle / 1 ringing / 2 snoozed
  int         m_tick, m_t, m_st, m_id, m_cnt;
  int         m_alm [NA];
  logic [3:0] m_en;
  logic       m_zero, m_ph, m_pm, m_ps, m_po;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asrt++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_tick = 0; m_t = 0; m_st = 0; m_id = 0; m_cnt = 0; m_en = '0; m_zero = 1'b0;
    m_ph = 1'b0; m_pm = 1'b0; m_ps = 1'b0; m_po = 1'b0;
    for (int i = 0; i < NA; i++) m_alm[i] = 0;
  endtask

  task automatic model_step();
    logic eh, em, es, eo, pulse, roll;
    int found, h, mn;
    eh = hour_up & ~m_ph; em = min_up & ~m_pm; es = snooze & ~m_ps; eo = alarm_off & ~m_po;
    pulse = (mode != 2'd1) && (m_tick == TD - 1);
    roll  = pulse && (m_t % 60 == 59);
    found = -1;
    for (int i = 0; i < NA; i++)
      if (found < 0 && m_zero && m_en[i] && m_alm[i] == m_t / 60) found = i;
    if (mode == 2'd1) m_st = 0;
    else if (m_st == 0) begin
      if (found >= 0) begin m_st = 1; m_id = found; m_cnt = 0; end
    end else if (m_st == 1) begin
      if (eo) m_st = 0;
      else if (es) begin m_st = 2; m_cnt = 0; end
      else if (roll) begin m_cnt++; if (m_cnt == RNG) m_st = 0; end
    end else begin
      if (eo) m_st = 0;
      else if (found >= 0) begin m_st = 1; m_id = found; m_cnt = 0; end
      else if (roll) begin m_cnt++; if (m_cnt == SNZ) begin m_st = 1; m_cnt = 0; end end
    end
    if (mode == 2'd1) begin
      m_tick = 0;
      h = (m_t / 3600 + (eh ? 1 : 0)) % 24;
      mn = ((m_t / 60) % 60 + (em ? 1 : 0)) % 60;
      m_t = h * 3600 + mn * 60;
    end else begin
      m_tick = (m_tick + 1) % TD;
      if (pulse) m_t = (m_t + 1) % 86400;
    end
    if (mode == 2'd2) begin
      h = (m_alm[alarm_sel] / 60 + (eh ? 1 : 0)) % 24;
      mn = (m_alm[alarm_sel] % 60 + (em ? 1 : 0)) % 60;
      m_alm[alarm_sel] = h * 60 + mn;
    end else if (mode == 2'd3 && em) begin
      m_en[alarm_sel] = ~m_en[alarm_sel];
    end
    m_zero = roll;
    m_ph = hour_up; m_pm = min_up; m_ps = snooze; m_po = alarm_off;
  endtask

  task automatic check_all();
    chk("hours", hours, m_t / 3600);
    chk("minutes", minutes, (m_t / 60) % 60);
    chk("seconds", seconds, m_t % 60);
    chk("alarm", alarm, m_st == 1);
    chk("alarm_id", alarm_id, m_id);
    chk("alarm_en", alarm_en, m_en);
    chk("sec_pulse", sec_pulse, (mode != 2'd1) && (m_tick == TD - 1));
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic cycles(input int n);
    repeat (n) cyc();
  endtask

  task automatic press_h();
    hour_up = 1'b1; cyc(); hour_up = 1'b0; cyc();
  endtask

  task automatic press_m();
    min_up = 1'b1; cyc(); min_up = 1'b0; cyc();
  endtask

  task automatic set_time_to(input int h, input int m);
    int nh, nm;
    mode = 2'd1; cyc();
    nh = (h - m_t / 3600 + 24) % 24;
    nm = (m - (m_t / 60) % 60 + 60) % 60;
    repeat (nh) press_h();
    repeat (nm) press_m();
  endtask

  task automatic set_alarm(input int slot, input int h, input int m);
    int nh, nm;
    mode = 2'd2; alarm_sel = 2'(slot); cyc();
    nh = (h - m_alm[slot] / 60 + 24) % 24;
    nm = (m - m_alm[slot] % 60 + 60) % 60;
    repeat (nh) press_h();
    repeat (nm) press_m();
    mode = 2'd0;
  endtask

  task automatic toggle_en(input int slot);
    mode = 2'd3; alarm_sel = 2'(slot); cyc(); press_m(); mode = 2'd0;
  endtask

  task automatic run_until_alarm(input logic lvl, input int budget);
    int k = 0;
    while (alarm !== lvl && k < budget) begin cyc(); k++; end
    chk("wait_alarm_level", alarm, lvl);
  endtask

  task automatic watch_no_ring(input string tag, input int n);
    logic seen = 1'b0;
    repeat (n) begin cyc(); if (alarm === 1'b1) seen = 1'b1; end
    chk(tag, seen, 1'b0);
  endtask

  initial begin
    clr = 1'b1; mode = 2'd0; alarm_sel = 2'd0;
    hour_up = 1'b0; min_up = 1'b0; snooze = 1'b0; alarm_off = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    clr = 1'b0;

    cycles(TD * 60);
    chk("run_one_minute", {hours, minutes, seconds}, {5'd0, 6'd1, 6'd0});

    mode = 2'd1; min_up = 1'b1; cycles(500); min_up = 1'b0; cyc();
    chk("held_min_up", {hours, minutes, seconds}, {5'd0, 6'd2, 6'd0});
    repeat (56) press_m();
    chk("min_58", minutes, 6'd58);
    repeat (61) press_m();
    chk("min_wrap_no_carry", {hours, minutes}, {5'd0, 6'd59});
    hour_up = 1'b1; min_up = 1'b1; cyc(); hour_up = 1'b0; min_up = 1'b0; cyc();
    chk("both_buttons", {hours, minutes}, {5'd1, 6'd0});

    repeat (22) press_h();
    repeat (59) press_m();
    mode = 2'd0;
    cycles(TD * 59);
    chk("preload_235959", {hours, minutes, seconds}, {5'd23, 6'd59, 6'd59});
    cycles(TD);
    chk("midnight_wrap", {hours, minutes, seconds}, {5'd0, 6'd0, 6'd0});

    set_alarm(2, 0, 2);
    toggle_en(2);
    set_time_to(0, 0);
    mode = 2'd0;
    run_until_alarm(1'b1, 1000);
    chk("ring_time", {hours, minutes, seconds}, {5'd0, 6'd2, 6'd0});
    chk("ring_id", alarm_id, 3'd2);

    snooze = 1'b1; cyc(); snooze = 1'b0;
    chk("snooze_drops", alarm, 1'b0);
    run_until_alarm(1'b1, 1500);
    chk("rering_time", {minutes, seconds}, {6'd7, 6'd0});
    chk("rering_id", alarm_id, 3'd2);
    alarm_off = 1'b1; snooze = 1'b1; cyc(); alarm_off = 1'b0; snooze = 1'b0;
    chk("off_beats_snooze", alarm, 1'b0);
    watch_no_ring("stays_idle", 400);

    set_alarm(1, 0, 20);
    set_alarm(3, 0, 20);
    toggle_en(1);
    toggle_en(3);
    set_time_to(0, 19);
    mode = 2'd0;
    run_until_alarm(1'b1, 600);
    chk("lowest_slot_wins", alarm_id, 3'd1);
    run_until_alarm(1'b0, 2600);
    chk("ring_timeout", {minutes, seconds}, {6'd30, 6'd0});

    toggle_en(1);
    toggle_en(3);
    set_time_to(0, 19);
    mode = 2'd0;
    watch_no_ring("disabled_slot", 600);

    toggle_en(3);
    set_time_to(0, 20);
    cycles(5);
    mode = 2'd0;
    watch_no_ring("set_time_no_match", 200);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) mode = 2'($urandom_range(0, 3));
      alarm_sel = 2'($urandom_range(0, 3));
      hour_up   = ($urandom_range(0, 3) == 0);
      min_up    = ($urandom_range(0, 3) == 0);
      snooze    = ($urandom_range(0, 7) == 0);
      alarm_off = ($urandom_range(0, 15) == 0);
      cyc();
    end
    hour_up = 1'b0; min_up = 1'b0; snooze = 1'b0; alarm_off = 1'b0; mode = 2'd0;
    cyc();

    set_alarm(0, 0, 25);
    if (!m_en[0]) toggle_en(0);
    set_time_to(0, 24);
    mode = 2'd0;
    run_until_alarm(1'b1, 600);
    chk("clr_ring_id", alarm_id, 3'd0);
    #2;
    clr = 1'b1;
    #1;
    model_reset();
    check_all();
    chk("clr_enables", alarm_en, 4'd0);
    @(posedge clk);
    #1;
    clr = 1'b0;
    cycles(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/alarm_clock_core.md
# alarm_clock_core

Parametrised timekeeping and multi-alarm core for the clock/alarm design. It divides the system clock to a one-second tick and keeps 24-hour time. It lets the user set time and any of NUM_ALARMS alarms through the existing mode/hour_up/min_up controls, and runs an alarm state machine with snooze and auto-timeout. Outputs are binary time fields plus alarm status; digit encoding and segment multiplexing stay in the display block downstream.

## Interface
- TICK_DIV, 50_000_000: clk cycles per second; must be ≥2.
- NUM_ALARMS, 4: independent alarm slots; range 1..8.
- SNOOZE_MIN, 5: minutes between snooze and re-ring; range 1..63.
- RING_MIN, 10: minutes of ringing before auto-off; range 1..63.
- clk  in  1  system clock, all state on rising edge.
- clr  in  1  reset, asynchronous, active-high.
- mode  in  2  0 RUN, 1 SET_TIME, 2 SET_ALARM, 3 ALARM_EN.
- alarm_sel  in  max(1,clog2(NUM_ALARMS))  selected alarm slot; values ≥NUM_ALARMS ignored.
- hour_up  in  1  debounced, synchronous level; acts on rising edge.
- min_up  in  1  debounced, synchronous level; acts on rising edge.
- snooze  in  1  level; acts on rising edge.
- alarm_off  in  1  level; acts on rising edge.
- hours  out  5  0..23.
- minutes  out  6  0..59.
- seconds  out  6  0..59.
- alarm  out  1  high while state RINGING.
- alarm_id  out  3  slot that caused current ring/snooze.
- alarm_en  out  NUM_ALARMS  enable bit per slot.
- sec_pulse  out  1  one-cycle pulse per second tick (RUN/SET_ALARM/ALARM_EN only).

## Operation
- Every output resets to 0. Reset also clears the tick counter, all alarm times (00:00), all enables, and the button edge registers. FSM resets to IDLE.
- Edge detect: each of hour_up, min_up, snooze, alarm_off has a registered previous value. An event is input=1 and prev=0. A held input produces exactly one event.
- Tick counter: 0..TICK_DIV-1, wraps; sec_pulse=1 in the cycle the counter equals TICK_DIV-1.
- RUN, SET_ALARM, ALARM_EN: on sec_pulse, seconds+1. 59→0 carries to minutes; minutes 59→0 carries to hours; hours 23→0.
- SET_TIME: tick counter held at 0, seconds forced 0, time frozen. min_up event: minutes+1, 59→0, no hour carry. hour_up event: hours+1, 23→0. Both events in the same cycle: both apply.
- SET_ALARM: same increment rules applied to the alarm[alarm_sel] hour/minute.
- ALARM_EN: min_up event toggles alarm_en[alarm_sel]. hour_up is ignored.
- Match: a slot matches when its enable is 1, its hh:mm equal the current time, and the current seconds became 0 via a RUN-type tick in the previous cycle. Setting the time to hh:mm never matches. The lowest matching index wins.
- FSM, IDLE: match → RINGING, alarm_id=index, minute counter=0.
- FSM, RINGING: alarm_off → IDLE. Otherwise snooze → SNOOZE with counter=0. Otherwise, on each minute rollover the counter increments; reaching RING_MIN → IDLE. A new match is ignored.
- FSM, SNOOZE: alarm_off → IDLE. Otherwise a new match → RINGING with the new alarm_id and counter=0. Otherwise the counter increments on minute rollover; reaching SNOOZE_MIN → RINGING (same alarm_id, counter=0). snooze is ignored.
- alarm_off and snooze in the same cycle: alarm_off wins.
- Entering SET_TIME from any FSM state forces IDLE in that cycle. alarm_id holds its last value in IDLE.
- Disabling the ringing slot in ALARM_EN does not stop the ring.

## Timing
- Seconds update on the edge ending the sec_pulse cycle. First increment is TICK_DIV cycles after clr falls.
- Match latency: alarm rises 1 cycle after seconds becomes 0 on a matching minute.
- Button events act on the edge after the input rises (1-cycle latency); alarm falls 1 cycle after the alarm_off rising edge.
- A minute rollover coinciding with alarm_off/snooze: the button action takes priority; the counter is not incremented in that cycle.
- clr mid-ring: alarm goes low asynchronously and immediately.

## Test plan
- TICK_DIV=4. Reset, RUN for 4*60 cycles → 00:01:00. Preload 23:59:59, one tick → 00:00:00.
- SET_TIME: hold min_up 500 cycles → minutes+1 only. Press min_up 61 times from 00:58 → 00:59, hours unchanged. Both buttons in one cycle → +1h +1m.
- Slot 2 at 00:02, enabled in ALARM_EN; RUN from 00:00:00 → alarm=1 exactly 1 cycle after 00:02:00, alarm_id=2. Slots 1 and 3 at the same time → alarm_id=1.
- Ringing, press snooze → alarm=0; after 5 minute rollovers alarm=1, alarm_id unchanged. alarm_off+snooze together → IDLE.
- Let it ring untouched → alarm drops at the 10th rollover. Disabled slot at matching time → no ring. Set time to alarm hh:mm in SET_TIME → no ring.
- Assert clr while ringing → all outputs 0 with no clock edge; enables cleared.
